// File: rtl/vec_strided_lsu_if.sv
// rtl/vec_strided_lsu_if.sv - 32-bit memory request/response port of the strided vector LSU
interface vec_strided_lsu_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/vec_strided_lsu.sv
// rtl/vec_strided_lsu.sv - strided vector load/store sequencer, one memory handshake per element
module vec_strided_lsu #(
    parameter int VLEN = 128,
    parameter int VLW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [31:0]       base,
    input  logic [31:0]       stride,
    input  logic [VLW-1:0]    vl,
    input  logic [1:0]        sew,
    input  logic [VLEN-1:0]   store_data,
    output logic [VLEN-1:0]   load_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    vec_strided_lsu_if.master mem
);
    localparam int             OFFW   = VLW + 5;
    localparam logic [VLW-1:0] VLMAX8 = VLW'(VLEN / 8);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, STEP, DONE} state_t;

    state_t          state;
    logic            is_store_q;
    logic [31:0]     addr_q;
    logic [31:0]     stride_q;
    logic [VLW-1:0]  vl_q;
    logic [1:0]      sew_q;
    logic [VLEN-1:0] store_q;
    logic [VLW-1:0]  n_q;
    logic [VLW-1:0]  idx_q;

    logic [VLW-1:0]  vlmax;
    logic [VLW-1:0]  n_eff;
    logic [VLW-1:0]  idx_nxt;
    logic [VLW-1:0]  req_idx;
    logic [31:0]     addr_nxt;
    logic [31:0]     req_addr;
    logic            req_last;
    logic            req_misaligned;
    logic [31:0]     elem_mask;
    logic [3:0]      strb_base;
    logic [31:0]     st_elem;
    logic [31:0]     rd_sh;
    logic [31:0]     ld_elem;
    logic [VLEN-1:0] ld_ins;

    // Bit position of element slot i inside the register image for a given sew.
    function automatic logic [OFFW-1:0] slot_offset(input logic [VLW-1:0] i, input logic [1:0] s);
        return ({5'b0, i} << s) << 3;
    endfunction

    // Geometry of the element about to be issued (current one in CHECK, next one in STEP)
    // so alignment is known before mem_valid is ever raised for it.
    always_comb begin
        vlmax          = VLMAX8 >> sew_q;
        n_eff          = (vl_q < vlmax) ? vl_q : vlmax;
        idx_nxt        = idx_q + VLW'(1);
        addr_nxt       = addr_q + stride_q;
        req_addr       = (state == STEP) ? addr_nxt : addr_q;
        req_idx        = (state == STEP) ? idx_nxt : idx_q;
        req_last       = (state == STEP) ? (idx_nxt == n_q) : (n_eff == '0);
        elem_mask      = 32'hffff_ffff;
        strb_base      = 4'b1111;
        req_misaligned = 1'b0;
        case (sew_q)
            2'b00: begin
                elem_mask = 32'h0000_00ff;
                strb_base = 4'b0001;
            end
            2'b01: begin
                elem_mask      = 32'h0000_ffff;
                strb_base      = 4'b0011;
                req_misaligned = req_addr[0];
            end
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b1;
        endcase
        st_elem = 32'(store_q >> slot_offset(req_idx, sew_q)) & elem_mask;
        rd_sh   = mem.mem_rdata >> {addr_q[1:0], 3'b000};
        ld_elem = rd_sh & elem_mask;
        ld_ins  = {{(VLEN-32){1'b0}}, ld_elem} << slot_offset(idx_q, sew_q);
    end

    // Sequencer: latches the command, walks the elements, drives memory port and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            addr_q        <= '0;
            stride_q      <= '0;
            vl_q          <= '0;
            sew_q         <= '0;
            store_q       <= '0;
            n_q           <= '0;
            idx_q         <= '0;
            load_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        addr_q     <= base;
                        stride_q   <= stride;
                        vl_q       <= vl;
                        sew_q      <= sew;
                        store_q    <= store_data;
                        idx_q      <= '0;
                        load_data  <= '0;
                        busy       <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK, STEP: begin
                    if (state == STEP) begin
                        addr_q <= addr_nxt;
                        idx_q  <= idx_nxt;
                    end else begin
                        n_q <= n_eff;
                    end
                    if ((state == CHECK && sew_q == 2'b11) || (!req_last && req_misaligned)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (req_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state         <= REQ;
                        mem.mem_valid <= 1'b1;
                        mem.mem_addr  <= {req_addr[31:2], 2'b00};
                        mem.mem_wdata <= is_store_q ? (st_elem << {req_addr[1:0], 3'b000}) : 32'h0;
                        mem.mem_wstrb <= is_store_q ? (strb_base << req_addr[1:0]) : 4'b0000;
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        if (!is_store_q) begin
                            load_data <= load_data | ld_ins;
                        end
                        state <= STEP;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vec_strided_lsu.md
Name: vec_strided_lsu

Overview:
Strided vector load/store sequencer inside the vector coprocessor. It sits between vector instruction decode (vlse.v / vsse.v with base in rs1, byte stride in rs2, vl/SEW from vsetvli) and the coprocessor's 32-bit memory port (vec_mem_*). It issues one memory handshake per element, extracts or inserts the element byte lanes, and packs loaded elements into a VLEN-bit register image for the vector register file.

Parameters:
VLEN, 128, vector register width in bits; must be a multiple of 32.
VLW, 8, width of the vl input; must hold VLEN/8.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle command strobe; sampled only in IDLE.
is_store  in  1  1 = strided store, 0 = strided load.
base  in  32  byte address of element 0.
stride  in  32  signed byte stride, two's complement.
vl  in  VLW  element count.
sew  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit; 11 is reserved and treated as an error.
store_data  in  VLEN  source register image; element i occupies bits [i*SEW +: SEW].
load_data  out  VLEN  packed load result, same layout as store_data.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle completion pulse.
error  out  1  valid with done: misaligned address or reserved sew.
mem_valid  out  1  memory request valid.
mem_ready  in  1  memory response / acknowledge.
mem_addr  out  32  word-aligned address: {addr[31:2], 2'b00}.
mem_wdata  out  32  store data, already shifted into its byte lane.
mem_wstrb  out  4  byte-enable mask; 0000 for loads.
mem_rdata  in  32  load data; valid in the mem_ready cycle.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE. Cleared to 0: busy, done, error, mem_valid, mem_addr, mem_wdata, mem_wstrb, load_data, and all internal counters. A transaction in flight is abandoned, and a mem_ready arriving after reset is ignored.
- States and transitions:
  - IDLE -> CHECK on start. All command inputs are latched, load_data is cleared to 0, busy goes high.
  - CHECK (1 cycle): computes VLMAX = VLEN/SEW; effective count n = min(vl, VLMAX).
    - sew==11 -> DONE with error.
    - n==0 -> DONE without error.
    - Otherwise -> REQ.
  - REQ: mem_valid=1. Alignment is checked first, every element: element address not a multiple of SEW/8 -> DONE with error, and no mem_valid is raised for that element. Otherwise, on mem_ready: a load writes (mem_rdata >> 8*addr[1:0]) masked to SEW into element slot idx; then -> STEP.
  - STEP (1 cycle): mem_valid=0, so valid is low for exactly one cycle between handshakes. addr += stride (mod 2^32); idx += 1. If idx reaches n -> DONE, else -> REQ.
  - DONE (1 cycle): done=1, error as determined; busy drops the following cycle -> IDLE.
- Memory port: mem_addr, mem_wdata and mem_wstrb are stable while mem_valid is high. Wait states of any length are allowed.
- Stores: mem_wdata = element << 8*addr[1:0]. mem_wstrb = (0001, 0011 or 1111 for SEW 8, 16, 32) << addr[1:0]. Bytes outside the element are never strobed.
- Loads: mem_wstrb=0000. Slots >= n read as 0. load_data holds its value after DONE until the next accepted start.
- Strides: stride 0 repeats the same address n times. Negative stride decrements the address. Address arithmetic wraps at 32 bits.
- vl > VLMAX is silently clamped (no error).
- start while busy is ignored. start in the DONE cycle is ignored.
- With the testbench memory (1-cycle ready), each element takes 3 cycles (REQ, ready, STEP). Total latency = 3n + 2 cycles from start to done.

Test Plan:
- Memory words at byte 400..412 = 04030201, 08070605, 0c0b0a09, 000f0e0d. Load sew=00, base=400, stride=2, vl=8 -> load_data[63:0]=0f0d0b09_07050301, upper bits 0, done at cycle 26, error=0.
- Load sew=01, base=400, stride=4, vl=4 -> load_data[63:0]=0e0d0a09_06050201. Load sew=00, base=403, stride=-1, vl=4 -> load_data[31:0]=01020304.
- Store sew=00, base=600, stride=1, vl=4, store_data[31:0]=44332211 -> 4 writes, all with mem_addr=600; wstrb 0001, 0010, 0100, 1000; word at 600 = 44332211.
- Load sew=10, base=402 -> done with error=1 and no mem_valid. Load vl=0 -> done with error=0 two cycles after start and no mem_valid. Load sew=00, vl=200 -> exactly 16 handshakes.
- Memory holding mem_ready off for 5 cycles -> mem_valid and mem_addr stay stable, data is captured correctly. Reset asserted in REQ -> mem_valid=0 and busy=0 immediately; a fresh start afterward runs normally.
